clk_div_param: RTL and testbench
================================

Name: clk_div_param

Overview:
- Parametrised integer clock divider, the next generation of the 4-bit `clk_div` used by the UART/ALU system clocking.
- Ratio width is generic. Ratio/enable changes are glitch-safe: they take effect only at a divided-period boundary, and the block acknowledges each adopted ratio.
- Keeps bypass semantics: ratio < 2 or disabled passes the reference clock through.
- Feeds UART TX/RX clock domains from the single reference clock.

Parameters:
- RATIO_WIDTH, 8, bit width of divide ratio and internal counter; max ratio 2^RATIO_WIDTH-1.

Ports:
- i_ref_clk  input  1  reference clock; sole clock of the block.
- i_rst  input  1  synchronous, active-high reset.
- i_clk_en  input  1  divider enable; 0 requests bypass.
- i_div_ratio  input  RATIO_WIDTH  requested divide ratio N.
- o_div_clk  output  1  divided clock (or i_ref_clk in bypass).
- o_active  output  1  1 when dividing (en_q=1 and ratio_q>=2).
- o_ratio_ack  output  1  one-cycle pulse when a new ratio value is adopted.

Behaviour:
- State registers: en_q, ratio_q[RATIO_WIDTH-1:0], cnt[RATIO_WIDTH-1:0], div_q, ack_q. All update on posedge i_ref_clk.
- Reset (i_rst=1 at posedge): en_q=0, ratio_q=0, cnt=0, div_q=0, ack_q=0.
- While i_rst=1, o_div_clk is forced 0 combinationally. o_active=0 and o_ratio_ack=0.
- active = en_q & (ratio_q >= 2). o_active = active.
- o_div_clk = i_rst ? 0 : (active ? div_q : i_ref_clk).
- Bypass output is combinational passthrough; this is the only combinational clock path.
- Inactive cycle (active=0): load en_q<=i_clk_en and ratio_q<=i_div_ratio; cnt<=0; div_q<=1 (precharge so the first divided cycle is high).
- Active cycle, let N=ratio_q and H=N>>1:
  - cnt_next = (cnt==N-1) ? 0 : cnt+1.
  - div_q <= (cnt_next < H).
  - Result: high for H ref cycles, low for N-H. Even N gives 50% duty; odd N gives low one cycle longer.
- Boundary (active and cnt==N-1):
  - en_q<=i_clk_en, ratio_q<=i_div_ratio, cnt<=0, div_q<=1.
  - New ratio or disable takes effect from the next ref cycle, i.e. the start of a fresh period.
  - Mid-period input changes are ignored until the boundary.
- Leaving active (disable, or new ratio 0/1) at the boundary switches the output to bypass on the next cycle. The preceding divided cycle was low, so there is no runt high pulse.
- o_ratio_ack: ack_q <= 1 on any load cycle (inactive or boundary) where i_div_ratio != ratio_q. Otherwise 0. Asserted exactly one cycle after the load edge.
- Reset mid-period: counter and output state cleared at that edge. After release the block loads inputs on the first inactive cycle and starts a fresh high phase; no partial period.
- Ratio = max (2^W-1): cnt never overflows; counter wraps only via the N-1 compare.
- Simultaneous i_rst and any input change: reset wins.

Optional Feature:
- Macro CLK_DIV_PARAM_RISE_STB_EN.
- Defined: extra output port o_rise_stb (1 bit), registered. It is 1 exactly during the ref cycle in which active=1 and cnt==0 (first high cycle of each divided period). It is 0 in bypass and in reset. Used as a clock-enable for logic kept on i_ref_clk.
- Undefined: port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset dominance: i_rst=1, i_clk_en=1, ratio=4 for 30 cycles -> o_div_clk=0, o_active=0, o_ratio_ack=0 throughout.
- Bypass: i_rst=0, i_clk_en=0, ratio=6 -> o_div_clk follows i_ref_clk, o_active=0. Same result for i_clk_en=1 with ratio=0 and with ratio=1.
- Even/odd division: ratio=4 -> 2 high/2 low repeating. Ratio=5 -> 2 high/3 low. Ratio=255 (W=8) -> 127 high/128 low. o_ratio_ack pulses once at adoption.
- Mid-period change: running ratio=6, change to 3 at cnt=2 -> current 6-cycle period completes unchanged, then 1 high/2 low. o_ratio_ack pulses the cycle after the boundary.
- Disable at boundary / reset mid-period: drop i_clk_en at cnt=1 of ratio 8 -> bypass begins exactly after cnt=7. Assert i_rst at cnt=3 -> output 0 next; after release with ratio 8 -> fresh 4 high/4 low.
- With CLK_DIV_PARAM_RISE_STB_EN, ratio=5 -> o_rise_stb high 1 cycle every 5, aligned to each o_div_clk rising phase. Always 0 in bypass.

Source files
------------

// File: rtl/clk_div_param.sv
//------------------------------------------------------------------------------
// Module      : clk_div_param
// Description : Parametrised integer clock divider with glitch-safe ratio and
//               enable changes. New settings are adopted only at a divided
//               period boundary (or while idle), and each adopted ratio is
//               acknowledged with a one-cycle pulse. Ratio < 2 or disable
//               passes the reference clock straight through.
//               Optional macro CLK_DIV_PARAM_RISE_STB_EN adds o_rise_stb, a
//               registered strobe marking the first high cycle of each period.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module clk_div_param #(
  parameter int RATIO_WIDTH = 8
) (
  input  logic                   i_ref_clk,
  input  logic                   i_rst,
  input  logic                   i_clk_en,
  input  logic [RATIO_WIDTH-1:0] i_div_ratio,
  output logic                   o_div_clk,
  output logic                   o_active,
  output logic                   o_ratio_ack
`ifdef CLK_DIV_PARAM_RISE_STB_EN
  ,
  output logic                   o_rise_stb
`endif
);

  localparam logic [RATIO_WIDTH-1:0] C_ONE = RATIO_WIDTH'(1);
  localparam logic [RATIO_WIDTH-1:0] C_TWO = RATIO_WIDTH'(2);

  logic                   r_en;
  logic [RATIO_WIDTH-1:0] r_ratio;
  logic [RATIO_WIDTH-1:0] r_cnt;
  logic                   r_div;
  logic                   r_ack;

  logic                   w_active;
  logic [RATIO_WIDTH-1:0] w_half;
  logic                   w_last;
  logic                   w_load;
  logic [RATIO_WIDTH-1:0] w_cnt_nxt;
  logic                   w_div_nxt;
  logic                   w_en_nxt;
  logic [RATIO_WIDTH-1:0] w_ratio_nxt;
  logic                   w_ack_nxt;

  // Next-state decode: settings are (re)loaded whenever idle or on the last
  // cycle of a divided period, so the output never sees a partial period.
  always_comb begin
    w_active    = r_en & (r_ratio >= C_TWO);
    w_half      = r_ratio >> 1;
    w_last      = (r_cnt == (r_ratio - C_ONE));
    w_load      = ~w_active | w_last;
    w_cnt_nxt   = w_load ? '0 : (r_cnt + C_ONE);
    // Precharge high on load so every fresh period starts with its high phase.
    w_div_nxt   = w_load ? 1'b1 : (w_cnt_nxt < w_half);
    w_en_nxt    = w_load ? i_clk_en : r_en;
    w_ratio_nxt = w_load ? i_div_ratio : r_ratio;
    w_ack_nxt   = w_load & (i_div_ratio != r_ratio);
  end

  // Divider state registers.
  always_ff @(posedge i_ref_clk) begin
    if (i_rst) begin
      r_en    <= 1'b0;
      r_ratio <= '0;
      r_cnt   <= '0;
      r_div   <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_en    <= w_en_nxt;
      r_ratio <= w_ratio_nxt;
      r_cnt   <= w_cnt_nxt;
      r_div   <= w_div_nxt;
      r_ack   <= w_ack_nxt;
    end
  end

  // Reset forces all outputs low; bypass is the only combinational clock path.
  assign o_div_clk   = i_rst ? 1'b0 : (w_active ? r_div : i_ref_clk);
  assign o_active    = w_active & ~i_rst;
  assign o_ratio_ack = r_ack & ~i_rst;

`ifdef CLK_DIV_PARAM_RISE_STB_EN
  logic r_rise;
  logic w_rise_nxt;

  // Strobe is true in the cycle where the loaded state is active with cnt==0.
  always_comb begin
    w_rise_nxt = w_en_nxt & (w_ratio_nxt >= C_TWO) & (w_cnt_nxt == '0);
  end

  // Rising-phase strobe register.
  always_ff @(posedge i_ref_clk) begin
    if (i_rst) begin
      r_rise <= 1'b0;
    end else begin
      r_rise <= w_rise_nxt;
    end
  end

  assign o_rise_stb = r_rise & ~i_rst;
`endif

endmodule

`default_nettype wire

// File: tb/tb_clk_div_param.sv
//------------------------------------------------------------------------------
// Module      : tb_clk_div_param
// Description : Self-checking bench for clk_div_param. A period-position
//               reference model predicts divided clock, active, ack and (when
//               CLK_DIV_PARAM_RISE_STB_EN is defined) the rise strobe.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_clk_div_param;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         clk_en;
  logic [W-1:0] div_ratio;
  logic         div_clk;
  logic         active;
  logic         ratio_ack;
`ifdef CLK_DIV_PARAM_RISE_STB_EN
  logic         rise_stb;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: programmed period length, position inside the period.
  int m_en  = 0;
  int m_n   = 0;
  int m_pos = 0;
  int m_ack = 0;

  clk_div_param #(.RATIO_WIDTH(W)) u_dut (
    .i_ref_clk   (clk),
    .i_rst       (rst),
    .i_clk_en    (clk_en),
    .i_div_ratio (div_ratio),
    .o_div_clk   (div_clk),
    .o_active    (active),
    .o_ratio_ack (ratio_ack)
`ifdef CLK_DIV_PARAM_RISE_STB_EN
    ,
    .o_rise_stb  (rise_stb)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit model_active();
    return (m_en != 0) && (m_n >= 2);
  endfunction

  // Advance the model by one reference edge using the inputs seen at it.
  task automatic model_edge(input logic r, input logic e, input int d);
    if (r) begin
      m_en = 0; m_n = 0; m_pos = 0; m_ack = 0;
    end else if (!model_active() || (m_pos == m_n - 1)) begin
      m_ack = (d != m_n) ? 1 : 0;
      m_en  = e ? 1 : 0;
      m_n   = d;
      m_pos = 0;
    end else begin
      m_pos = m_pos + 1;
      m_ack = 0;
    end
  endtask

  // One reference cycle: apply inputs just after the edge, check both phases.
  task automatic tick(input logic r, input logic e, input int d);
    bit exp_hi;
    @(posedge clk);
    model_edge(rst, clk_en, int'(div_ratio));
    #1;
    rst       = r;
    clk_en    = e;
    div_ratio = W'(d);
    #2;
    exp_hi = model_active() ? (m_pos < (m_n / 2)) : 1'b1;
    check("div_clk_hi", 32'(div_clk), rst ? 32'd0 : 32'(exp_hi));
    check("active",     32'(active),  rst ? 32'd0 : 32'(model_active()));
    check("ratio_ack",  32'(ratio_ack), rst ? 32'd0 : 32'(m_ack));
`ifdef CLK_DIV_PARAM_RISE_STB_EN
    check("rise_stb",   32'(rise_stb),
          (rst || !model_active()) ? 32'd0 : 32'(m_pos == 0));
`endif
    @(negedge clk);
    #1;
    check("div_clk_lo", 32'(div_clk),
          (rst || !model_active()) ? 32'd0 : 32'(m_pos < (m_n / 2)));
  endtask

  task automatic run(input int cycles, input logic r, input logic e, input int d);
    for (int i = 0; i < cycles; i++) tick(r, e, d);
  endtask

  initial begin
    logic cur_rst;
    logic cur_en;
    int   cur_d;

    rst = 1'b1; clk_en = 1'b1; div_ratio = W'(4);

    // Reset dominance with an active-looking request.
    run(30, 1'b1, 1'b1, 4);

    // Bypass: disabled, ratio 0, ratio 1.
    run(10, 1'b0, 1'b0, 6);
    run(10, 1'b0, 1'b1, 0);
    run(10, 1'b0, 1'b1, 1);

    // Even, odd and maximum ratios.
    run(16, 1'b0, 1'b1, 4);
    run(4,  1'b0, 1'b1, 4);
    run(22, 1'b0, 1'b1, 5);
    run(520, 1'b0, 1'b1, 255);

    // Mid-period ratio change 6 -> 3 presented at cnt=2.
    run(20, 1'b0, 1'b1, 6);
    for (int k = 0; k < 16 && m_pos != 2; k++) tick(1'b0, 1'b1, 6);
    run(20, 1'b0, 1'b1, 3);

    // Disable at cnt=1 of ratio 8.
    run(20, 1'b0, 1'b1, 8);
    for (int k = 0; k < 16 && m_pos != 1; k++) tick(1'b0, 1'b1, 8);
    run(16, 1'b0, 1'b0, 8);

    // Reset at cnt=3 of ratio 8, then a fresh 4/4 period after release.
    run(12, 1'b0, 1'b1, 8);
    for (int k = 0; k < 16 && m_pos != 3; k++) tick(1'b0, 1'b1, 8);
    run(2, 1'b1, 1'b1, 8);
    run(24, 1'b0, 1'b1, 8);

    // Randomised segment with held ratios, sporadic disables and resets.
    cur_en = 1'b1;
    cur_d  = 4;
    for (int i = 0; i < 3000; i++) begin
      cur_rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 19) == 0) cur_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 14) == 0)
        cur_d = ($urandom_range(0, 49) == 0) ? 255 : int'($urandom_range(0, 12));
      tick(cur_rst, cur_en, cur_d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
